// File: rtl/ts_fifo_wr_arb.sv
// Write-side arbiter for the timestamp FIFO. It arbitrates TX/RX capture sources,
// tags each entry with its source and lost flag, and sequences aclr flushes.
// Optional drop counters are enabled by defining TS_ARB_DROP_CNT_EN.
module ts_fifo_wr_arb #(
    parameter int FIFO_W       = 80,
    parameter int USEDW_W      = 4,
    parameter int FULL_THRESH  = 14,
    parameter bit DROP_ON_FULL = 1'b1,
    parameter int FLUSH_CYC    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s0_valid,
    output logic                s0_ready,
    input  logic [FIFO_W-5:0]   s0_ts,
    input  logic                s1_valid,
    output logic                s1_ready,
    input  logic [FIFO_W-5:0]   s1_ts,
    input  logic                flush_req,
    output logic                flush_done,
    output logic                busy,
    output logic [FIFO_W-1:0]   fifo_data,
    output logic                fifo_wrreq,
    output logic                fifo_aclr,
    input  logic [USEDW_W-1:0]  fifo_wrusedw,
    input  logic                fifo_wrfull
`ifdef TS_ARB_DROP_CNT_EN
    ,
    output logic [15:0]         drop_cnt0,
    output logic [15:0]         drop_cnt1
`endif
);

    localparam int CNT_W = $clog2(FLUSH_CYC + 1);
    localparam logic [USEDW_W:0] THRESH_V = (USEDW_W + 1)'(FULL_THRESH);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_FLUSH = 1'b1} state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic [CNT_W-1:0]   flush_cnt_r;
    logic               lost0_r;
    logic               lost1_r;
    logic               rr_last_r;
    logic               space_s;
    logic               room_ok_s;
    logic               gnt0_s;
    logic               gnt1_s;
    logic               acc0_s;
    logic               acc1_s;
    logic               wr_s;
    logic               drop0_s;
    logic               drop1_s;

    // The threshold leaves one slot for the write still in flight
    assign space_s   = !fifo_wrfull && ({1'b0, fifo_wrusedw} < THRESH_V);
    assign room_ok_s = space_s || DROP_ON_FULL;
    assign acc0_s    = s0_valid && s0_ready;
    assign acc1_s    = s1_valid && s1_ready;
    assign wr_s      = (acc0_s || acc1_s) && space_s;
    assign drop0_s   = acc0_s && !space_s;
    assign drop1_s   = acc1_s && !space_s;

    // State register and flush cycle counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            flush_cnt_r <= '0;
        end else begin
            state_r <= next_state_s;
            if ((state_r == ST_FLUSH) && (next_state_s == ST_FLUSH)) begin
                flush_cnt_r <= flush_cnt_r + CNT_W'(1);
            end else begin
                flush_cnt_r <= '0;
            end
        end
    end

    // Next-state logic; FLUSH spans one lead-in cycle plus FLUSH_CYC aclr cycles
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (flush_req) begin
                    next_state_s = ST_FLUSH;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_r == CNT_W'(FLUSH_CYC)) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_FLUSH;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Round-robin grant and combinational readies
    always_comb begin
        gnt0_s   = 1'b0;
        gnt1_s   = 1'b0;
        s0_ready = 1'b0;
        s1_ready = 1'b0;
        if (rst_n && (state_r == ST_IDLE)) begin
            gnt0_s   = s0_valid && (!s1_valid || rr_last_r);
            gnt1_s   = s1_valid && (!s0_valid || !rr_last_r);
            s0_ready = gnt0_s && room_ok_s;
            s1_ready = gnt1_s && room_ok_s;
        end else begin
            gnt0_s   = 1'b0;
            gnt1_s   = 1'b0;
        end
    end

    // aclr rises one cycle into FLUSH so a write accepted alongside flush_req lands first
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fifo_aclr  <= 1'b1;
            busy       <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            fifo_aclr  <= (state_r == ST_FLUSH) && (next_state_s == ST_FLUSH);
            busy       <= (next_state_s == ST_FLUSH);
            flush_done <= (state_r == ST_FLUSH) && (next_state_s == ST_IDLE);
        end
    end

    // FIFO write port, lost flags and round-robin pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fifo_wrreq <= 1'b0;
            fifo_data  <= '0;
            lost0_r    <= 1'b0;
            lost1_r    <= 1'b0;
            rr_last_r  <= 1'b1;
        end else begin
            fifo_wrreq <= wr_s;
            if (wr_s) begin
                fifo_data <= acc1_s ? {2'b01, lost1_r, 1'b0, s1_ts}
                                    : {2'b00, lost0_r, 1'b0, s0_ts};
            end
            if (state_r == ST_FLUSH) begin
                lost0_r <= 1'b0;
                lost1_r <= 1'b0;
            end else begin
                if (acc0_s) lost0_r <= drop0_s;
                if (acc1_s) lost1_r <= drop1_s;
            end
            if (acc0_s) begin
                rr_last_r <= 1'b0;
            end else if (acc1_s) begin
                rr_last_r <= 1'b1;
            end
        end
    end

`ifdef TS_ARB_DROP_CNT_EN
    // Saturating drop counters; flush leaves them untouched
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt0 <= 16'h0000;
            drop_cnt1 <= 16'h0000;
        end else begin
            if (drop0_s && (drop_cnt0 != 16'hFFFF)) drop_cnt0 <= drop_cnt0 + 16'h0001;
            if (drop1_s && (drop_cnt1 != 16'hFFFF)) drop_cnt1 <= drop_cnt1 + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_ts_fifo_wr_arb.sv
// Scoreboard bench for ts_fifo_wr_arb: drop-on-full instance plus a backpressure
// instance. Drop counter checks compile in only with TS_ARB_DROP_CNT_EN.
module tb_ts_fifo_wr_arb;
    logic        clk = 1'b0;
    logic        rst_n, s0_valid, s1_valid, b_s0_valid, flush_req, fifo_wrfull;
    logic        b_s1_valid = 1'b0;
    logic [75:0] s0_ts, s1_ts;
    logic [3:0]  fifo_wrusedw;
    logic        s0_ready, s1_ready, flush_done, busy, fifo_wrreq, fifo_aclr;
    logic [79:0] fifo_data;
    logic        b_s0_ready, b_s1_ready, b_flush_done, b_busy, b_fifo_wrreq, b_fifo_aclr;
    logic [79:0] b_fifo_data;
`ifdef TS_ARB_DROP_CNT_EN
    logic [15:0] drop_cnt0, drop_cnt1, b_drop_cnt0, b_drop_cnt1;
`endif

    int          checks = 0;
    int          fails = 0;
    logic [79:0] exp_q[$];
    logic [79:0] exp_w;
    logic        exp_rr, exp_lost0, exp_lost1, g;

    always #5 clk = ~clk;

    ts_fifo_wr_arb dut (
        .clk(clk), .rst_n(rst_n),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_ts(s0_ts),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_ts(s1_ts),
        .flush_req(flush_req), .flush_done(flush_done), .busy(busy),
        .fifo_data(fifo_data), .fifo_wrreq(fifo_wrreq), .fifo_aclr(fifo_aclr),
        .fifo_wrusedw(fifo_wrusedw), .fifo_wrfull(fifo_wrfull)
`ifdef TS_ARB_DROP_CNT_EN
        , .drop_cnt0(drop_cnt0), .drop_cnt1(drop_cnt1)
`endif
    );

    ts_fifo_wr_arb #(.DROP_ON_FULL(1'b0)) dut_bp (
        .clk(clk), .rst_n(rst_n),
        .s0_valid(b_s0_valid), .s0_ready(b_s0_ready), .s0_ts(s0_ts),
        .s1_valid(b_s1_valid), .s1_ready(b_s1_ready), .s1_ts(s1_ts),
        .flush_req(flush_req), .flush_done(b_flush_done), .busy(b_busy),
        .fifo_data(b_fifo_data), .fifo_wrreq(b_fifo_wrreq), .fifo_aclr(b_fifo_aclr),
        .fifo_wrusedw(fifo_wrusedw), .fifo_wrfull(fifo_wrfull)
`ifdef TS_ARB_DROP_CNT_EN
        , .drop_cnt0(b_drop_cnt0), .drop_cnt1(b_drop_cnt1)
`endif
    );

    task automatic test_reset();
        rst_n = 1'b0; s0_valid = 1'b1; s1_valid = 1'b1; b_s0_valid = 1'b1;
        flush_req = 1'b0; fifo_wrfull = 1'b0; fifo_wrusedw = 4'd0;
        s0_ts = 76'h1; s1_ts = 76'h2;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({s0_ready, s1_ready, b_s0_ready, b_s1_ready} !== 4'b0000) begin
            fails++; $display("FAIL reset_ready: got %b required 0000", {s0_ready, s1_ready, b_s0_ready, b_s1_ready});
        end
        checks++;
        if ({fifo_wrreq, fifo_aclr, busy, flush_done, b_busy, b_flush_done} !== 6'b010000) begin
            fails++; $display("FAIL reset_ctrl: got %b required 010000", {fifo_wrreq, fifo_aclr, busy, flush_done, b_busy, b_flush_done});
        end
        checks++;
        if (fifo_data !== 80'h0) begin
            fails++; $display("FAIL reset_data: got %h required 0", fifo_data);
        end
        s0_valid = 1'b0; s1_valid = 1'b0; b_s0_valid = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({fifo_aclr, b_fifo_aclr} !== 2'b00) begin
            fails++; $display("FAIL reset_aclr_release: got %b required 00", {fifo_aclr, b_fifo_aclr});
        end
        exp_rr = 1'b1; exp_lost0 = 1'b0; exp_lost1 = 1'b0; exp_q.delete();
    endtask

    task automatic test_alternate();
        fifo_wrusedw = 4'd0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k > 0) begin
                exp_w = exp_q.pop_front();
                checks++;
                if (fifo_wrreq !== 1'b1 || fifo_data !== exp_w) begin
                    fails++; $display("FAIL alt_write: got wrreq=%b data=%h required 1 %h", fifo_wrreq, fifo_data, exp_w);
                end
            end
            s0_valid = 1'b1; s1_valid = 1'b1;
            s0_ts = {44'h0, 32'($urandom)}; s1_ts = {44'h1, 32'($urandom)};
            #1;
            g = ~exp_rr;
            checks++;
            if (s0_ready !== ~g || s1_ready !== g) begin
                fails++; $display("FAIL alt_grant: got %b%b required %b%b", s0_ready, s1_ready, ~g, g);
            end
            exp_q.push_back({g ? 2'b01 : 2'b00, g ? exp_lost1 : exp_lost0, 1'b0, g ? s1_ts : s0_ts});
            if (g) exp_lost1 = 1'b0; else exp_lost0 = 1'b0;
            exp_rr = g;
        end
        @(negedge clk);
        s0_valid = 1'b0; s1_valid = 1'b0;
        exp_w = exp_q.pop_front();
        checks++;
        if (fifo_wrreq !== 1'b1 || fifo_data !== exp_w) begin
            fails++; $display("FAIL alt_last: got wrreq=%b data=%h required 1 %h", fifo_wrreq, fifo_data, exp_w);
        end
        @(negedge clk);
        checks++;
        if (fifo_wrreq !== 1'b0) begin
            fails++; $display("FAIL alt_idle_wrreq: got %b required 0", fifo_wrreq);
        end
    endtask

    task automatic test_drop_tag();
        @(negedge clk);
        s1_valid = 1'b1; s1_ts = 76'h5; fifo_wrusedw = 4'd14;
        #1;
        checks++;
        if (s1_ready !== 1'b1) begin
            fails++; $display("FAIL drop_ready: got %b required 1", s1_ready);
        end
        exp_lost1 = 1'b1; exp_rr = 1'b1;
        @(negedge clk);
        checks++;
        if (fifo_wrreq !== 1'b0) begin
            fails++; $display("FAIL drop_no_wrreq: got %b required 0", fifo_wrreq);
        end
`ifdef TS_ARB_DROP_CNT_EN
        checks++;
        if (drop_cnt1 !== 16'd1) begin
            fails++; $display("FAIL drop_cnt1: got %0d required 1", drop_cnt1);
        end
`endif
        fifo_wrusedw = 4'd0; s1_ts = 76'h6;
        exp_q.push_back({2'b01, exp_lost1, 1'b0, s1_ts}); exp_lost1 = 1'b0;
        @(negedge clk);
        exp_w = exp_q.pop_front();
        checks++;
        if (fifo_wrreq !== 1'b1 || fifo_data !== exp_w || fifo_data[77] !== 1'b1) begin
            fails++; $display("FAIL lost_tag_set: got wrreq=%b data=%h required 1 %h", fifo_wrreq, fifo_data, exp_w);
        end
        s1_ts = 76'h7;
        exp_q.push_back({2'b01, exp_lost1, 1'b0, s1_ts});
        @(negedge clk);
        s1_valid = 1'b0;
        exp_w = exp_q.pop_front();
        checks++;
        if (fifo_wrreq !== 1'b1 || fifo_data !== exp_w || fifo_data[77] !== 1'b0) begin
            fails++; $display("FAIL lost_tag_clear: got wrreq=%b data=%h required 1 %h", fifo_wrreq, fifo_data, exp_w);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        b_s0_valid = 1'b1; s0_ts = 76'hABC; fifo_wrfull = 1'b1; fifo_wrusedw = 4'd0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (b_s0_ready !== 1'b0 || b_s1_ready !== 1'b0) begin
                fails++; $display("FAIL bp_full_ready: got %b%b required 00", b_s0_ready, b_s1_ready);
            end
            @(negedge clk);
            checks++;
            if (b_fifo_wrreq !== 1'b0) begin
                fails++; $display("FAIL bp_full_wrreq: got %b required 0", b_fifo_wrreq);
            end
        end
        fifo_wrfull = 1'b0; fifo_wrusedw = 4'd14;
        #1;
        checks++;
        if (b_s0_ready !== 1'b0) begin
            fails++; $display("FAIL bp_thresh14: got %b required 0", b_s0_ready);
        end
        fifo_wrusedw = 4'd13;
        #1;
        checks++;
        if (b_s0_ready !== 1'b1) begin
            fails++; $display("FAIL bp_thresh13: got %b required 1", b_s0_ready);
        end
        @(negedge clk);
        b_s0_valid = 1'b0; fifo_wrusedw = 4'd0;
        checks++;
        if (b_fifo_wrreq !== 1'b1 || b_fifo_data !== {2'b00, 1'b0, 1'b0, 76'hABC}) begin
            fails++; $display("FAIL bp_write: got wrreq=%b data=%h required 1 %h", b_fifo_wrreq, b_fifo_data, {4'b0000, 76'hABC});
        end
    endtask

    task automatic test_flush();
        int aclr_n = 0;
        int done_n = 0;
        int bad_n = 0;
        @(negedge clk);
        s0_valid = 1'b1; s0_ts = 76'h11; fifo_wrusedw = 4'd14;
        exp_lost0 = 1'b1; exp_rr = 1'b0;
        @(negedge clk);
        s0_valid = 1'b0; s1_valid = 1'b1; s1_ts = 76'h22; fifo_wrusedw = 4'd0; flush_req = 1'b1;
        #1;
        checks++;
        if (s1_ready !== 1'b1) begin
            fails++; $display("FAIL flush_same_cycle_ready: got %b required 1", s1_ready);
        end
        exp_q.push_back({2'b01, exp_lost1, 1'b0, s1_ts}); exp_rr = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            aclr_n += int'(fifo_aclr);
            done_n += int'(flush_done);
            if (fifo_aclr && !busy) bad_n++;
            if (k == 0) begin
                exp_w = exp_q.pop_front();
                checks++;
                if (fifo_wrreq !== 1'b1 || fifo_data !== exp_w || fifo_aclr !== 1'b0 || busy !== 1'b1) begin
                    fails++; $display("FAIL flush_pending_write: got wrreq=%b aclr=%b busy=%b data=%h required 1 0 1 %h", fifo_wrreq, fifo_aclr, busy, fifo_data, exp_w);
                end
            end else if (fifo_wrreq !== 1'b0) begin
                bad_n++;
            end
            s1_valid = 1'b0; s0_valid = busy; flush_req = (k == 2);
            #1;
            if (busy && (s0_ready !== 1'b0)) bad_n++;
        end
        exp_lost0 = 1'b0;
        checks++;
        if (aclr_n !== 4) begin
            fails++; $display("FAIL flush_aclr_cycles: got %0d required 4", aclr_n);
        end
        checks++;
        if (done_n !== 1) begin
            fails++; $display("FAIL flush_done_pulses: got %0d required 1", done_n);
        end
        checks++;
        if (bad_n !== 0) begin
            fails++; $display("FAIL flush_busy_ready: got %0d violations required 0", bad_n);
        end
        @(negedge clk);
        s0_valid = 1'b1; s0_ts = 76'h33;
        exp_q.push_back({2'b00, exp_lost0, 1'b0, s0_ts}); exp_rr = 1'b0;
        @(negedge clk);
        s0_valid = 1'b0;
        exp_w = exp_q.pop_front();
        checks++;
        if (fifo_wrreq !== 1'b1 || fifo_data !== exp_w) begin
            fails++; $display("FAIL flush_lost_cleared: got data=%h required %h", fifo_data, exp_w);
        end
`ifdef TS_ARB_DROP_CNT_EN
        checks++;
        if (drop_cnt0 !== 16'd1 || drop_cnt1 !== 16'd1) begin
            fails++; $display("FAIL flush_keeps_cnt: got %0d %0d required 1 1", drop_cnt0, drop_cnt1);
        end
`endif
    endtask

    task automatic test_reset_mid_write();
        @(negedge clk);
        s0_valid = 1'b1; s1_valid = 1'b1; s0_ts = 76'h44; s1_ts = 76'h55; fifo_wrusedw = 4'd0;
        g = ~exp_rr;
        exp_q.push_back({g ? 2'b01 : 2'b00, g ? exp_lost1 : exp_lost0, 1'b0, g ? s1_ts : s0_ts});
        @(negedge clk);
        exp_w = exp_q.pop_front();
        checks++;
        if (fifo_wrreq !== 1'b1 || fifo_data !== exp_w) begin
            fails++; $display("FAIL rst_pre_write: got wrreq=%b data=%h required 1 %h", fifo_wrreq, fifo_data, exp_w);
        end
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({fifo_wrreq, fifo_aclr, busy, s0_ready, s1_ready} !== 5'b01000 || fifo_data !== 80'h0) begin
            fails++; $display("FAIL rst_mid_write: got %b data=%h required 01000 0", {fifo_wrreq, fifo_aclr, busy, s0_ready, s1_ready}, fifo_data);
        end
        s0_valid = 1'b0; s1_valid = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        exp_rr = 1'b1; exp_lost0 = 1'b0; exp_lost1 = 1'b0;
        checks++;
        if (fifo_aclr !== 1'b0) begin
            fails++; $display("FAIL rst_aclr_fall: got %b required 0", fifo_aclr);
        end
        s0_valid = 1'b1; s1_valid = 1'b1; s0_ts = 76'h66; s1_ts = 76'h77;
        #1;
        checks++;
        if (s0_ready !== 1'b1 || s1_ready !== 1'b0) begin
            fails++; $display("FAIL rst_first_tie: got %b%b required 10", s0_ready, s1_ready);
        end
        exp_q.push_back({2'b00, 1'b0, 1'b0, s0_ts}); exp_rr = 1'b0;
        @(negedge clk);
        s0_valid = 1'b0; s1_valid = 1'b0;
        exp_w = exp_q.pop_front();
        checks++;
        if (fifo_wrreq !== 1'b1 || fifo_data !== exp_w) begin
            fails++; $display("FAIL rst_first_write: got data=%h required %h", fifo_data, exp_w);
        end
    endtask

`ifdef TS_ARB_DROP_CNT_EN
    task automatic test_drop_saturate();
        @(negedge clk);
        s0_valid = 1'b1; fifo_wrusedw = 4'd14;
        repeat (65534) @(negedge clk);
        checks++;
        if (drop_cnt0 !== 16'hFFFE) begin
            fails++; $display("FAIL sat_below: got %h required FFFE", drop_cnt0);
        end
        repeat (3) @(negedge clk);
        s0_valid = 1'b0; fifo_wrusedw = 4'd0;
        checks++;
        if (drop_cnt0 !== 16'hFFFF || fifo_wrreq !== 1'b0) begin
            fails++; $display("FAIL sat_hold: got %h wrreq=%b required FFFF 0", drop_cnt0, fifo_wrreq);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_alternate();
        test_drop_tag();
        test_backpressure();
        test_flush();
        test_reset_mid_write();
`ifdef TS_ARB_DROP_CNT_EN
        test_drop_saturate();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
